// File: rtl/kpn_fifo_channel.sv
// Bounded KPN channel FIFO with registered read data and a one-cycle valid pulse.
// Optional sticky overflow/underflow flags and a high-water mark are enabled by KPN_FIFO_STATS_EN.
module kpn_fifo_channel #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
`ifdef KPN_FIFO_STATS_EN
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   max_count,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  wr_accept, rd_accept;

`ifdef KPN_FIFO_STATS_EN
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH:0]   max_count_q, max_count_d;
`endif

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == {(ADDR_WIDTH+1){1'b0}});

  // When full, a simultaneous read frees the slot being written, so both proceed.
  always_comb begin
    wr_accept  = wr && (!full || rd);
    rd_accept  = rd && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d = mem[rd_ptr_q];
      valid_d    = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef KPN_FIFO_STATS_EN
  always_comb begin
    overflow_d  = overflow_q | (wr && full && !rd);
    underflow_d = underflow_q | (rd && empty);
    if (count_d > max_count_q) begin
      max_count_d = count_d;
    end else begin
      max_count_d = max_count_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {(ADDR_WIDTH+1){1'b0}};
      data_out_q  <= {DATA_WIDTH{1'b0}};
      valid_q     <= 1'b0;
`ifdef KPN_FIFO_STATS_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      max_count_q <= {(ADDR_WIDTH+1){1'b0}};
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
`ifdef KPN_FIFO_STATS_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      max_count_q <= max_count_d;
`endif
    end
  end

  // Storage is deliberately left uninitialised by reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign count     = count_q;
`ifdef KPN_FIFO_STATS_EN
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Bench for kpn_fifo_channel: queue-based reference model, directed scenarios and random traffic.
// Stats outputs are checked when KPN_FIFO_STATS_EN is defined.
module tb_kpn_fifo_channel;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out, full, empty;
  logic [AW:0]   count;
`ifdef KPN_FIFO_STATS_EN
  logic          overflow, underflow;
  logic [AW:0]   max_count;
`endif

  kpn_fifo_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
`ifdef KPN_FIFO_STATS_EN
    .overflow(overflow), .underflow(underflow), .max_count(max_count),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_valid;
  bit            m_ovf, m_udf;
  int            m_max;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the negedge, advance the model at posedge, compare at the next negedge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit rst);
    bit was_full, was_empty;
    wr = w; data_in = d; rd = r; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_max = 0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (w && was_full && !r) m_ovf = 1;
      if (r && was_empty) m_udf = 1;
      if (r && !was_empty) begin
        m_dout = q.pop_front(); m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (w && (!was_full || r)) q.push_back(d);
      if (q.size() > m_max) m_max = q.size();
    end
    @(negedge clk);
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_dout);
`ifdef KPN_FIFO_STATS_EN
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
    check("max_count", max_count, m_max);
`endif
    wr = 0; rd = 0; reset = 0;
  endtask

  task automatic idle(); step(0, '0, 0, 0); endtask
  task automatic push(input logic [DW-1:0] d); step(1, d, 0, 0); endtask
  task automatic pop(); step(0, '0, 1, 0); endtask

  initial begin
    @(negedge clk);
    // 1: reset and idle
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) idle();
    check("t1_empty", empty, 1);
    check("t1_full", full, 0);
    check("t1_count", count, 0);
    check("t1_dout", data_out, 16'h0000);
    check("t1_valid", valid_out, 0);

    // 2: three writes, three reads
    push(16'h0003); push(16'h0007); push(16'h000B);
    pop(); check("t2_d0", data_out, 16'h0003); check("t2_v0", valid_out, 1);
    pop(); check("t2_d1", data_out, 16'h0007); check("t2_v1", valid_out, 1);
    pop(); check("t2_d2", data_out, 16'h000B); check("t2_empty", empty, 1);
    idle(); check("t2_vdrop", valid_out, 0); check("t2_hold", data_out, 16'h000B);

    // 3: fill, overflow attempt, drain
    for (int i = 1; i <= 8; i++) push(DW'(i));
    check("t3_full", full, 1); check("t3_count", count, 8);
    push(16'hFFFF);
    check("t3_full2", full, 1); check("t3_count2", count, 8);
`ifdef KPN_FIFO_STATS_EN
    check("t3_ovf", overflow, 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      pop(); check("t3_rd", data_out, DW'(i));
    end
    check("t3_empty", empty, 1);

    // 4: pointer wrap
    for (int i = 0; i < 6; i++) push(DW'(16'h0050 + i));
    for (int i = 0; i < 6; i++) pop();
    for (int i = 0; i < 6; i++) push(DW'(16'h0100 + i));
    for (int i = 0; i < 6; i++) begin
      pop(); check("t4_rd", data_out, DW'(16'h0100 + i));
    end
    check("t4_count", count, 0);

    // 5: full with simultaneous read and write
    for (int i = 0; i < 8; i++) push(DW'(16'h0020 + i));
    step(1, 16'hABCD, 1, 0);
    check("t5_count", count, 8); check("t5_oldest", data_out, 16'h0020);
    for (int i = 1; i <= 8; i++) begin
      pop(); check("t5_rd", data_out, (i == 8) ? 16'hABCD : DW'(16'h0020 + i));
    end

    // 6: empty with simultaneous read and write, then reset mid-operation
    step(1, 16'h1234, 1, 0);
    check("t6_valid", valid_out, 0); check("t6_count", count, 1);
    pop(); check("t6_rd", data_out, 16'h1234); check("t6_v", valid_out, 1);
    for (int i = 0; i < 4; i++) push(DW'(16'h0A00 + i));
    check("t6_count4", count, 4);
    step(1, 16'h5555, 1, 1);
    check("t6_rcount", count, 0); check("t6_rempty", empty, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int mode;
      mode = (n / 300) % 3;
      step($urandom_range(0, 99) < (mode == 0 ? 70 : (mode == 1 ? 30 : 50)),
           DW'($urandom),
           $urandom_range(0, 99) < (mode == 0 ? 30 : (mode == 1 ? 70 : 50)),
           $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
